// File: rtl/mem_loader.sv
// Burst loader: accepts a valid/ready word stream and writes len words into
// consecutive scratch-memory addresses starting at base, wrapping modulo Size.
module mem_loader #(
    parameter  int N    = 32,
    parameter  int Size = 64,
    localparam int Bits = $clog2(Size)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [Bits-1:0] base,
    input  logic [Bits:0]   len,
    input  logic            in_valid,
    input  logic [N-1:0]    in_data,
    output logic            in_ready,
    output logic            mem_write,
    output logic [Bits-1:0] mem_adr,
    output logic [N-1:0]    mem_din,
    output logic            busy,
    output logic            done,
    output logic [Bits:0]   count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [Bits:0]   SizeW = (Bits + 1)'(Size);
    localparam logic [Bits-1:0] LastAdr = Bits'(Size - 1);

    state_t          state;
    logic [Bits-1:0] ptr;
    logic [Bits:0]   len_r;
    logic            accept;

    assign in_ready = (state == LOAD) && !abort;
    assign busy     = (state == LOAD);
    assign accept   = in_valid && in_ready;

    // Explicit wrap compare keeps the pointer correct for non-power-of-2 depths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            len_r     <= '0;
            count     <= '0;
            mem_write <= 1'b0;
            mem_adr   <= '0;
            mem_din   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    mem_write <= 1'b0;
                    if (start) begin
                        ptr   <= base;
                        len_r <= (len > SizeW) ? SizeW : len;
                        count <= '0;
                        if (len == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        mem_write <= 1'b0;
                        state     <= IDLE;
                    end else if (accept) begin
                        mem_write <= 1'b1;
                        mem_adr   <= ptr;
                        mem_din   <= in_data;
                        ptr       <= (ptr == LastAdr) ? '0 : ptr + 1'b1;
                        count     <= count + 1'b1;
                        if (count == len_r - 1'b1) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end else begin
                        mem_write <= 1'b0;
                    end
                end
                FIN: begin
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_write <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream feeder for the word-addressed scratch memory.
- Accepts a valid/ready stream of N-bit words and writes a burst of len words into consecutive memory addresses, starting at a programmable base.
- Drives the memory's write-enable, address and data-in ports directly.
- Reports busy, a one-cycle done pulse and the count of words written.

Parameters:
- N, 32, data word width; matches memory word width.
- Size, 64, memory depth in words.
- Bits (localparam), $clog2(Size), address width.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin burst; sampled in IDLE only.
- abort  input  1  synchronous burst cancel.
- base  input  Bits  first write address; latched on start.
- len  input  Bits+1  burst length in words, 0..Size; latched on start.
- in_valid  input  1  upstream word valid.
- in_data  input  N  upstream word.
- in_ready  output  1  loader can accept a word this cycle.
- mem_write  output  1  memory write enable, registered.
- mem_adr  output  Bits  memory address, registered.
- mem_din  output  N  memory write data, registered.
- busy  output  1  high in LOAD.
- done  output  1  one-cycle completion pulse.
- count  output  Bits+1  words accepted in current or last burst.

Behaviour:
- Reset (async, immediate) values:
  - state = IDLE.
  - mem_write = 0, mem_adr = 0, mem_din = 0.
  - count = 0, done = 0, internal ptr = 0, len_r = 0.
- States: IDLE, LOAD, DONE. busy = (state == LOAD).
- in_ready = (state == LOAD) && !abort. This is combinational; there is no dependence on in_valid.
- IDLE:
  - start = 1: ptr <= base, len_r <= len, count <= 0.
  - Next state is LOAD if len != 0; DONE if len == 0.
  - start = 0: stay in IDLE.
- LOAD:
  - Accept = in_valid && in_ready.
  - On accept: mem_write <= 1, mem_adr <= ptr, mem_din <= in_data, ptr <= ptr + 1, count <= count + 1.
  - ptr wraps modulo Size (Size-1 -> 0); this also applies to non-power-of-2 Size.
  - Without accept: mem_write <= 0; mem_adr and mem_din hold.
  - Accept with count == len_r - 1: next state DONE.
- DONE: done = 1 for exactly this one cycle, mem_write <= 0, next state IDLE. start is ignored in DONE.
- Latency: a word accepted at edge k appears on mem_* during the cycle after edge k, and the memory captures it at edge k+1. done asserts in the cycle after the final accept edge, which is the same cycle the final write is presented.
- Throughput: one word per cycle under continuous in_valid.
- abort in LOAD: no accept that cycle; next state IDLE, mem_write <= 0, count holds its partial value, done is not pulsed. abort in IDLE or DONE has no effect.
- start while LOAD or DONE: ignored; base and len are not re-latched.
- len > Size: clamp len_r to Size.
- count holds its final value in IDLE until the next start.
- rst asserted mid-burst: immediate return to reset values. No partial write is issued after rst; a write already presented is dropped because mem_write clears asynchronously.
- Burst wrapping past address Size-1 overwrites from address 0; this is intended, not flagged.

Test Plan:
- Basic burst: base = 0, len = 4, in_valid held high, data 0xA0..0xA3 -> mem_write high for 4 consecutive cycles with adr 0..3 and din 0xA0..0xA3. done pulses once, in the cycle of the adr 3 write. count = 4.
- Back-pressure gaps: base = 10, len = 3, in_valid pattern 1,0,0,1,0,1 -> exactly 3 writes to adr 10, 11, 12 in the cycles after each valid. mem_write is low in the gap cycles. done follows the third write.
- Wrap-around: base = 62, len = 4 (Size = 64) -> writes to adr 62, 63, 0, 1 in order. count = 4, done pulses.
- Zero length and clamp: len = 0 -> IDLE→DONE→IDLE, done pulse with no mem_write and count = 0. len = 100 -> exactly 64 writes, then done.
- Abort and ignored start: len = 8, abort after 3 accepts -> IDLE, count = 3, no done, no further mem_write. A start during LOAD with a different base does not change the address sequence.
- Async reset mid-burst: rst pulsed between clock edges after 2 writes -> all outputs return to 0 immediately with no edge needed, state IDLE. A subsequent fresh start with base = 5, len = 2 writes adr 5 and 6 correctly.
